// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in / parallel-out word receiver.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    PAR      = 2'd2,
    WAIT_LOW = 2'd3
  } sipo_state_e;

  localparam int SIPO_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/sipo_receiver_if.sv
// Serial link pins plus the parallel valid/ready output of the receiver.
interface sipo_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH
);
  logic             sin;
  logic             sframe;
  logic             pready;
  logic [WIDTH-1:0] pdata;
  logic             pvalid;
  logic             ferr;
  logic             ovr;
  logic             perr;

  // master: transmitter and consumer side; slave: the receiver itself
  modport master (
    output sin, sframe, pready,
    input  pdata, pvalid, ferr, ovr, perr
  );

  modport slave (
    input  sin, sframe, pready,
    output pdata, pvalid, ferr, ovr, perr
  );
endinterface

// File: rtl/sipo_shift_reg.sv
// Shift-left register: new bit enters the LSB, so the first bit ends in the MSB.
module sipo_shift_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (clr_i) begin
      sh_d = '0;
    end else if (en_i) begin
      sh_d = {sh_q[WIDTH-2:0], d_i};
    end
  end

  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

  assign q_o = sh_q;
endmodule

// File: rtl/sipo_receiver.sv
// Serial word receiver: MSB-first frame -> parallel word on valid/ready, with abort/overrun pulses.
// Build option PARITY_CHECK_EN adds a trailing even-parity bit and the perr pulse.
module sipo_receiver
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic clk,
  input logic rst,
  sipo_if.slave bus
);
  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_SHIFT    = SHIFT;
  localparam logic [1:0] ST_WAIT_LOW = WAIT_LOW;
`ifdef PARITY_CHECK_EN
  localparam logic [1:0] ST_PAR      = PAR;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pdata_q, pdata_d;
  logic             pvalid_q, pvalid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  logic             shift_en;
  logic             abort;
  logic             word_done;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word;

  sipo_shift_reg #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .clr_i (rst | abort),
    .en_i  (shift_en),
    .d_i   (bus.sin),
    .q_o   (shreg)
  );

`ifdef PARITY_CHECK_EN
  logic perr_q, perr_d;
  logic par_bad;

  // data bits are all in the register by the time the parity bit arrives
  assign word = shreg;
`else
  // final data bit is merged combinationally so the word lands on the same edge
  assign word = {shreg[WIDTH-2:0], bus.sin};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_en  = 1'b0;
    abort     = 1'b0;
    word_done = 1'b0;
`ifdef PARITY_CHECK_EN
    par_bad   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.sframe) begin
          shift_en = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!bus.sframe) begin
          abort   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          shift_en = 1'b1;
          cnt_d    = (cnt_q == CNT_W'(WIDTH)) ? cnt_q : CNT_W'(cnt_q + 1'b1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
            state_d = ST_PAR;
`else
            word_done = 1'b1;
            state_d   = ST_WAIT_LOW;
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      ST_PAR: begin
        if (!bus.sframe) begin
          abort   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_LOW;
          if (bus.sin == (^shreg)) begin
            word_done = 1'b1;
          end else begin
            par_bad = 1'b1;
          end
        end
      end
`endif
      ST_WAIT_LOW: begin
        if (!bus.sframe) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // a completion wins over a plain consume; a consume in the same cycle frees the slot for it
  always_comb begin
    pdata_d  = pdata_q;
    pvalid_d = pvalid_q;
    ferr_d   = abort;
    ovr_d    = 1'b0;
    if (word_done) begin
      if (!pvalid_q || bus.pready) begin
        pdata_d  = word;
        pvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (pvalid_q && bus.pready) begin
      pvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pdata_q  <= '0;
      pvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pdata_q  <= pdata_d;
      pvalid_q <= pvalid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

`ifdef PARITY_CHECK_EN
  assign perr_d = par_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign bus.perr = perr_q;
`else
  assign bus.perr = 1'b0;
`endif

  assign bus.pdata  = pdata_q;
  assign bus.pvalid = pvalid_q;
  assign bus.ferr   = ferr_q;
  assign bus.ovr    = ovr_q;
endmodule

// File: tb/tb_sipo_receiver.sv
// Scoreboard bench for sipo_receiver: a frame-level model predicts every cycle's outputs.
module tb_sipo_receiver;
  import sipo_pkg::*;

  localparam int W = 8;
`ifdef PARITY_CHECK_EN
  localparam int FL     = W + 1;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int FL     = W;
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sipo_if #(.WIDTH(W)) bus ();

  sipo_receiver #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int           e;
    logic         pv;
    logic [W-1:0] pd;
    logic         fe;
    logic         ov;
    logic         pe;
  } exp_t;

  exp_t q[$];
  int   edges = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) edges <= edges + 1;

  // reference model: bits of the frame in flight, the output slot, and a "frame already used" flag
  bit           m_bits[$];
  bit           m_wait = 1'b0;
  bit           m_full = 1'b0;
  logic [W-1:0] m_word = '0;
  int           rdy_pct = 100;

  task automatic model_edge(input bit r, input bit sf, input bit si, input bit rdy);
    exp_t         x;
    bit           done;
    bit           fe;
    bit           ov;
    bit           pe;
    bit           okpar;
    logic [W-1:0] w;
    done = 1'b0; fe = 1'b0; ov = 1'b0; pe = 1'b0; w = '0;
    if (r) begin
      m_bits.delete();
      m_wait = 1'b0;
      m_full = 1'b0;
      m_word = '0;
    end else begin
      if (m_wait) begin
        if (!sf) m_wait = 1'b0;
      end else if (sf) begin
        m_bits.push_back(si);
        if (m_bits.size() == FL) begin
          for (int i = 0; i < W; i++) w[W-1-i] = m_bits[i];
          if (PAR_EN) okpar = (m_bits[W] == (^w));
          else        okpar = 1'b1;
          done = okpar;
          pe   = !okpar;
          m_bits.delete();
          m_wait = 1'b1;
        end
      end else if (m_bits.size() > 0) begin
        fe = 1'b1;
        m_bits.delete();
      end
      if (done) begin
        if (!m_full || rdy) begin
          m_word = w;
          m_full = 1'b1;
        end else begin
          ov = 1'b1;
        end
      end else if (m_full && rdy) begin
        m_full = 1'b0;
      end
    end
    x.e = edges + 1; x.pv = m_full; x.pd = m_word; x.fe = fe; x.ov = ov; x.pe = pe;
    q.push_back(x);
  endtask

  // one clock of stimulus; rf < 0 picks pready randomly from rdy_pct
  task automatic cyc(input bit r, input bit sf, input bit si, input int rf);
    bit rdy;
    if (rf < 0) rdy = ($urandom_range(0, 99) < rdy_pct);
    else        rdy = rf[0];
    rst        = r;
    bus.sframe = sf;
    bus.sin    = si;
    bus.pready = rdy;
    model_edge(r, sf, si, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w, input int nb, input bit badpar,
                      input int last_rdy, input int gap);
    bit b;
    for (int i = 0; i < nb; i++) begin
      if (i < W)                 b = w[W-1-i];
      else if (i == W && PAR_EN) b = (^w) ^ badpar;
      else                       b = 1'($urandom_range(0, 1));
      cyc(1'b0, 1'b1, b, (i == nb - 1) ? last_rdy : -1);
    end
    for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), -1);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].e <= edges) begin
        x = q.pop_front();
        total++;
        if (bus.pvalid !== x.pv) begin
          bad++;
          $display("FAIL pvalid edge=%0d got=%0b want=%0b", x.e, bus.pvalid, x.pv);
        end
        total++;
        if (bus.pdata !== x.pd) begin
          bad++;
          $display("FAIL pdata edge=%0d got=%02h want=%02h", x.e, bus.pdata, x.pd);
        end
        total++;
        if (bus.ferr !== x.fe) begin
          bad++;
          $display("FAIL ferr edge=%0d got=%0b want=%0b", x.e, bus.ferr, x.fe);
        end
        total++;
        if (bus.ovr !== x.ov) begin
          bad++;
          $display("FAIL ovr edge=%0d got=%0b want=%0b", x.e, bus.ovr, x.ov);
        end
        total++;
        if (bus.perr !== x.pe) begin
          bad++;
          $display("FAIL perr edge=%0d got=%0b want=%0b", x.e, bus.perr, x.pe);
        end
      end
    end
  end

  initial begin
    int k;
    int nb;
    rst = 1'b1; bus.sframe = 1'b0; bus.sin = 1'b0; bus.pready = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, 0);

    // basic frame
    rdy_pct = 100;
    send(8'hA5, FL, 1'b0, -1, 2);

    // backpressure and overrun, then drain
    rdy_pct = 0;
    send(8'h3C, FL, 1'b0, -1, 1);
    send(8'hC3, FL, 1'b0, -1, 2);
    rdy_pct = 100;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, -1);

    // accept-and-replace at the completion edge
    rdy_pct = 0;
    send(8'h11, FL, 1'b0, -1, 2);
    send(8'h22, FL, 1'b0, 1, 2);
    rdy_pct = 100;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, -1);

    // aborted frame, then a full one
    send(8'hE7, 5, 1'b0, -1, 2);
    send(8'hFF, FL, 1'b0, -1, 2);

    // reset in the middle of a frame
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), -1);
    cyc(1'b1, 1'b1, 1'b1, -1);
    cyc(1'b0, 1'b0, 1'b0, -1);
    send(8'h5A, FL, 1'b0, -1, 2);

    // overlong frame: extra bits ignored
    send(8'h96, FL + 3, 1'b0, -1, 2);

`ifdef PARITY_CHECK_EN
    send(8'hA5, FL, 1'b0, -1, 2);
    send(8'hA5, FL, 1'b1, -1, 2);
`endif

    repeat (80) begin
      k = $urandom_range(0, 9);
      if (k < 7)      nb = FL;
      else if (k < 9) nb = $urandom_range(1, FL - 1);
      else            nb = FL + $urandom_range(1, 3);
      rdy_pct = $urandom_range(0, 100);
      send(W'($urandom), nb, ($urandom_range(0, 3) == 0), -1, $urandom_range(1, 3));
    end

    rdy_pct = 100;
    repeat (4) cyc(1'b0, 1'b0, 1'b0, -1);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
